// File: rtl/edge_dec_pkg.sv
// Shared types and constants for the edge_decoder run-length receiver.
// Optional statistics/saturation build: define EDGE_DEC_STAT_EN.
package edge_dec_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 4;

    // Run-length entry for the default configuration; the top re-declares it at its own CNT_W.
    typedef struct packed {
        logic                 lvl;
        logic [CNT_W_DEF-1:0] len;
    } run_entry_t;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/edge_dec_fifo.sv
// Synchronous circular FIFO of run entries; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module edge_dec_fifo
    import edge_dec_pkg::*;
#(
    parameter type         entry_t = run_entry_t,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   empty_o,
    output logic   drop_o
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_q, rd_q;
    entry_t           mem_q [DEPTH];
    logic             full, empty, do_pop, do_push;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                  (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
        do_pop  = pop_i && !empty;
        // A pop in the same cycle frees the slot the new entry lands in.
        do_push = push_i && (!full || do_pop);
        drop_o  = push_i && full && !do_pop;
        empty_o = empty;
        head_o  = mem_q[rd_q[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[IDX_W-1:0]] <= push_data_i;
                wr_q                   <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/edge_decoder.sv
// Rebuilds a level from its edge-pulse stream and queues the length of each completed run.
// Define EDGE_DEC_STAT_EN for a saturating run counter and the sticky err output.
module edge_decoder
    import edge_dec_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] run_len,
    output logic             run_lvl,
    output logic             run_valid,
    input  logic             run_ready
`ifdef EDGE_DEC_STAT_EN
    ,
    output logic             err
`endif
);

    typedef struct packed {
        logic             lvl;
        logic [CNT_W-1:0] len;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_c;
    entry_t           push_entry, head;
    logic             empty;
`ifdef EDGE_DEC_STAT_EN
    logic             err_q, err_d, sat_c, drop;
`else
    logic             drop_unused;
`endif

    // Next level, run counter and push entry; len is the count including this pulse cycle.
    always_comb begin
        out_d = out_q ^ in;
        len_c = cnt_q + CNT_W'(1);
`ifdef EDGE_DEC_STAT_EN
        sat_c = (cnt_q == CNT_MAX);
        if (sat_c) begin
            len_c = CNT_MAX;
        end
        err_d = err_q | sat_c | drop;
`endif
        cnt_d      = in ? '0 : len_c;
        push_entry = '{lvl: out_q, len: len_c};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= 1'b0;
            cnt_q <= '0;
`ifdef EDGE_DEC_STAT_EN
            err_q <= 1'b0;
`endif
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
`ifdef EDGE_DEC_STAT_EN
            err_q <= err_d;
`endif
        end
    end

    edge_dec_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (in),
        .push_data_i (push_entry),
        .pop_i       (run_ready),
        .head_o      (head),
        .empty_o     (empty),
`ifdef EDGE_DEC_STAT_EN
        .drop_o      (drop)
`else
        .drop_o      (drop_unused)
`endif
    );

    assign out       = out_q;
    assign run_valid = !empty;
    assign run_len   = head.len;
    assign run_lvl   = head.lvl;
`ifdef EDGE_DEC_STAT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_edge_decoder.sv
// Directed self-checking bench for edge_decoder (CNT_W=4, DEPTH=4).
module tb_edge_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             in_r = 1'b0;
    logic             ready_r = 1'b0;
    logic             out_w;
    logic [CNT_W-1:0] len_w;
    logic             lvl_w;
    logic             valid_w;
`ifdef EDGE_DEC_STAT_EN
    logic             err_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_decoder #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in_r),
        .out       (out_w),
        .run_len   (len_w),
        .run_lvl   (lvl_w),
        .run_valid (valid_w),
        .run_ready (ready_r)
`ifdef EDGE_DEC_STAT_EN
        ,
        .err       (err_w)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, return at the following falling edge.
    task automatic tick(input logic p, input logic r);
        in_r    = p;
        ready_r = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_head(input string tag, input logic lvl, input int len);
        check({tag, ".valid"}, 32'(valid_w), 32'd1);
        check({tag, ".lvl"},   32'(lvl_w),   32'(lvl));
        check({tag, ".len"},   32'(len_w),   32'(len));
    endtask

    // Hold reset two cycles with in toggling; release at a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst.valid_async", 32'(valid_w), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(1'(i % 2 == 0), 1'b0);
            check("rst.out",   32'(out_w),   32'd0);
            check("rst.valid", 32'(valid_w), 32'd0);
            check("rst.len",   32'(len_w),   32'd0);
            check("rst.lvl",   32'(lvl_w),   32'd0);
`ifdef EDGE_DEC_STAT_EN
            check("rst.err",   32'(err_w),   32'd0);
`endif
        end
        in_r = 1'b0;
        rstn = 1'b1;
    endtask

    initial begin
        #2;
        @(negedge clk);

        // Pulses at cycles 3 and 8 after release.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(1'(c == 3 || c == 8), 1'b1);
            if (c == 2) check("pulse.out_c2", 32'(out_w), 32'd0);
            if (c == 3) begin
                check("pulse.out_rise", 32'(out_w), 32'd1);
                expect_head("pulse.e0", 1'b0, 4);
            end
            if (c == 4) check("pulse.pop", 32'(valid_w), 32'd0);
            if (c == 8) begin
                check("pulse.out_fall", 32'(out_w), 32'd0);
                expect_head("pulse.e1", 1'b1, 5);
            end
            if (c == 9) check("pulse.empty", 32'(valid_w), 32'd0);
        end

        // Three back-to-back pulses.
        do_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("b2b.out1", 32'(out_w), 32'd1);
        expect_head("b2b.e0", 1'b0, 2);
        tick(1'b1, 1'b1);
        check("b2b.out2", 32'(out_w), 32'd0);
        expect_head("b2b.e1", 1'b1, 1);
        tick(1'b1, 1'b1);
        check("b2b.out3", 32'(out_w), 32'd1);
        expect_head("b2b.e2", 1'b0, 1);
        tick(1'b0, 1'b1);
        check("b2b.drained", 32'(valid_w), 32'd0);

        // Backpressure: six pulses into four slots, last two dropped.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            tick(1'(c == 0 || c == 2 || c == 5 || c == 9 || c == 10 || c == 12), 1'b0);
            expect_head("bp.stall", 1'b0, 1);
        end
`ifdef EDGE_DEC_STAT_EN
        check("bp.err", 32'(err_w), 32'd1);
`endif
        in_r    = 1'b0;
        ready_r = 1'b1;
        #1;
        expect_head("bp.d0", 1'b0, 1);
        tick(1'b0, 1'b1);
        expect_head("bp.d1", 1'b1, 2);
        tick(1'b0, 1'b1);
        expect_head("bp.d2", 1'b0, 3);
        tick(1'b0, 1'b1);
        expect_head("bp.d3", 1'b1, 4);
        tick(1'b0, 1'b1);
        check("bp.empty", 32'(valid_w), 32'd0);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(1'(c == 0 || c == 2 || c == 5 || c == 9), 1'b0);
        end
        expect_head("pp.full_head", 1'b0, 1);
        tick(1'b1, 1'b1);
        expect_head("pp.h0", 1'b1, 2);
        tick(1'b0, 1'b1);
        expect_head("pp.h1", 1'b0, 3);
        tick(1'b0, 1'b1);
        expect_head("pp.h2", 1'b1, 4);
        tick(1'b0, 1'b1);
        expect_head("pp.new", 1'b0, 3);
        tick(1'b0, 1'b1);
        check("pp.empty", 32'(valid_w), 32'd0);
`ifdef EDGE_DEC_STAT_EN
        check("pp.err", 32'(err_w), 32'd0);
`endif

        // Long run: 20 idle cycles then a pulse.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b1);
        end
        check("ovf.no_entry", 32'(valid_w), 32'd0);
        tick(1'b1, 1'b1);
        check("ovf.out", 32'(out_w), 32'd1);
`ifdef EDGE_DEC_STAT_EN
        expect_head("ovf.sat", 1'b0, 15);
        check("ovf.err", 32'(err_w), 32'd1);
`else
        expect_head("ovf.wrap", 1'b0, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_decoder.md
# edge_decoder

Receive-side counterpart of the exp1 XOR edge detector. It takes the single-cycle edge-pulse stream that the detector produces and rebuilds the original level. It also measures how many cycles each level lasted and queues those run-lengths in a small FIFO, read out over a valid/ready handshake. It sits directly downstream of the edge detector in the exp1 pair and uses the same clock and reset.

## Interface
- `CNT_W`, default 8: width of the run-length counter and of `run_len`.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `clk`, input, 1: rising-edge clock for all state.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `in`, input, 1: edge-pulse stream; 1 for a cycle means the source level toggled.
- `out`, output, 1: reconstructed level.
- `run_len`, output, CNT_W: length in cycles of the completed run at the FIFO head.
- `run_lvl`, output, 1: level held during that run.
- `run_valid`, output, 1: FIFO non-empty; head entry is presented.
- `run_ready`, input, 1: consumer accepts the head entry.
- `err`, output, 1: sticky error flag. Present only with `EDGE_DEC_STAT_EN`.

## Operation
- Level reconstruction:
  - `out` <= `out ^ in` on every rising clock edge.
  - Consecutive pulses are legal; `out` toggles on each one.
- Run counter `cnt`:
  - Increments on each cycle where `in`=0.
  - On a cycle where `in`=1, a push entry {lvl=`out` (pre-toggle value), len=`cnt`+1} is formed and `cnt` <= 0.
  - Overflow of `cnt` is handled as defined under Configuration.
  - The len=`cnt`+1 computation uses the same rule.
- FIFO:
  - Circular buffer of DEPTH entries, each {lvl, len}.
  - Write and read pointers are log2(DEPTH)+1 bits wide. Full is detected when the MSBs differ and the remaining bits are equal.
  - Pop occurs when `run_valid` && `run_ready`.
  - Push when not full: the entry is written.
  - Push when full with no pop in the same cycle: the entry is dropped and the FIFO is unchanged.
  - Push and pop in the same cycle when full: both occur; the new entry is accepted.
  - Push and pop in the same cycle when empty: not possible, because `run_valid`=0 when empty.
- Handshake:
  - `run_len` and `run_lvl` come from registered storage.
  - They are stable while `run_valid` && !`run_ready`.
  - `run_valid` does not depend combinationally on `run_ready`.

## Timing
- Reset values: `out`=0, `cnt`=0, pointers=0, `run_valid`=0, `run_len`=0, `run_lvl`=0, `err`=0.
- Asserting `rstn` mid-operation flushes the FIFO. The first run after release starts counting from the first clock edge with `rstn`=1.
- `out` changes one cycle after the clock edge that samples `in`=1.
- Push-to-valid latency is one cycle: an entry pushed at edge N appears at the head with `run_valid`=1 after edge N.
- Pop takes effect at the clock edge. The next entry (or `run_valid`=0) appears after that same edge.
- Throughput is one push and one pop per cycle.

## Configuration
- With `EDGE_DEC_STAT_EN` defined:
  - `cnt` saturates at 2^CNT_W−1.
  - A run reaching saturation reports len=2^CNT_W−1.
  - Port `err` exists. It is set by a counter saturation or by any dropped push, and is cleared only by reset.
- Without the macro:
  - There is no `err` port.
  - `cnt` and len wrap modulo 2^CNT_W.
  - Drops are silent.

## Structure
- Package `edge_dec_pkg` holds:
  - the entry struct typedef {lvl, len};
  - the pointer-width function clog2(DEPTH)+1;
  - default constants for CNT_W and DEPTH.
- Sub-module `edge_dec_fifo` (parameterised sync FIFO with full/empty and drop-on-full) is instantiated once. The top level holds the toggle register and the run counter.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles with `in` toggling -> `out`=0, `run_valid`=0, `err`=0 throughout.
- Pulses: `in`=1 at cycles 3 and 8 after release, `run_ready`=1 ->
  - `out` rises after cycle 3 and falls after cycle 8;
  - entries {lvl0, len4} and {lvl1, len5} appear one cycle after each pulse.
- Back-to-back: `in`=1 for 3 consecutive cycles -> `out` toggles each cycle; entries of len1 are pushed for the 2nd and 3rd pulses.
- Backpressure: `run_ready`=0, 6 pulses with DEPTH=4 ->
  - 4 entries are retained and the last 2 are dropped;
  - `err`=1 with the macro;
  - on raising `run_ready`, the 4 entries drain in order, one per cycle, with data stable while stalled.
- Full with simultaneous push and pop: FIFO full, `run_ready`=1 on the same cycle as a pulse -> occupancy stays 4, the new entry is kept, no drop, `err` unchanged.
- Overflow with CNT_W=4: no pulse for 20 cycles, then a pulse ->
  - with the macro: len=15 and `err`=1;
  - without it: len=(20+1) mod 16=5.
